// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
// Holds the divider FSM state type, the default operand width and a helper that
// sizes step counters for a given operand width.
package arith_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Counter width for counting down from w-1 to 0; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cla_subtractor.sv
// Combinational N-bit subtractor a - b computed as a + ~b + 1 with carry lookahead.
// Ports:
//   a    - minuend
//   b    - subtrahend
//   diff - a - b (modulo 2^N)
//   cout - carry out; 1 means a >= b (no borrow)
module cla_subtractor #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         cout
);

  logic [N-1:0] gen;
  logic [N-1:0] prop;
  logic [N:0]   carry;

  assign gen  = a & ~b;
  assign prop = a ^ ~b;

  // Each carry is formed from the group generate/propagate of all lower bits and the
  // carry-in of 1, rather than rippling through the previous carry.
  always_comb begin
    logic grp_g;
    logic grp_p;
    carry    = '0;
    carry[0] = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int j = 0; j <= i; j++) begin
        grp_g = gen[j] | (prop[j] & grp_g);
        grp_p = grp_p & prop[j];
      end
      carry[i+1] = grp_g | grp_p;
    end
  end

  assign diff = prop ^ carry[N-1:0];
  assign cout = carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   start        - request, sampled only when idle
//   dividend     - unsigned dividend, captured on acceptance
//   divisor      - unsigned divisor, captured on acceptance
//   busy         - high from the cycle after acceptance until done
//   done         - one-cycle pulse, results valid while high and held afterwards
//   quotient     - unsigned quotient (all ones on divide-by-zero)
//   remainder    - unsigned remainder (dividend on divide-by-zero)
//   div_by_zero  - set with done when the captured divisor was zero
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [CntW-1:0]  cnt_q;
  logic             dz_q;

  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   trial_d;
  logic             trial_c;

  // A restored remainder is always below the divisor, so its top bit stays zero.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_q[WIDTH];

  assign trial_s = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};

  cla_subtractor #(
    .N(WIDTH + 1)
  ) u_sub (
    .a   (trial_s),
    .b   ({1'b0, div_q}),
    .diff(trial_d),
    .cout(trial_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rem_q       <= '0;
      quo_q       <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      dz_q        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            div_q       <= divisor;
            cnt_q       <= CntW'(WIDTH - 1);
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              // Preload the divide-by-zero result so DONE can publish R/Q unchanged.
              dz_q    <= 1'b1;
              rem_q   <= {1'b0, dividend};
              quo_q   <= '1;
              state_q <= StDone;
            end else begin
              dz_q    <= 1'b0;
              rem_q   <= '0;
              quo_q   <= dividend;
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          if (trial_c) begin
            rem_q <= trial_d;
            quo_q <= {quo_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= trial_s;
            quo_q <= {quo_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == '0) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          done        <= 1'b1;
          busy        <= 1'b0;
          quotient    <= quo_q;
          remainder   <= rem_q[WIDTH-1:0];
          div_by_zero <= dz_q;
          state_q     <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;
  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  // Reference: plain integer division with the divide-by-zero convention.
  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 1;
    end else begin
      q = a / b; r = a % b; z = 1'b0; lat = W + 1;
    end
  endtask

  // Issue one operation; lat = 0 means done never came within the budget.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = W'($urandom); divisor = W'($urandom);
    busy_cnt = busy ? 1 : 0;
    lat = 0; q = 'x; r = 'x; z = 1'bx;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k; q = quotient; r = remainder; z = div_by_zero;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; dividend = 4'd9; divisor = 4'd2;
    repeat (3) @(posedge clk);
    #1;
    n_cmp += 5;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    if (quotient !== '0) begin n_bad++; $display("FAIL reset_quotient: got %0d want 0", quotient); end
    if (remainder !== '0) begin n_bad++; $display("FAIL reset_remainder: got %0d want 0", remainder); end
    if (div_by_zero !== 1'b0) begin n_bad++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    @(negedge clk);
    start = 1'b0; rst = 1'b0;
  endtask

  task automatic test_directed();
    // {dividend, divisor, quotient, remainder, div_by_zero, latency}
    logic [W-1:0] ta [7] = '{4'd13, 4'd15, 4'd5, 4'd0, 4'd7, 4'd6, 4'd14};
    logic [W-1:0] tb [7] = '{4'd3,  4'd1,  4'd9, 4'd7, 4'd0, 4'd2, 4'd4};
    logic [W-1:0] tq [7] = '{4'd4,  4'd15, 4'd0, 4'd0, 4'd15, 4'd3, 4'd3};
    logic [W-1:0] tr [7] = '{4'd1,  4'd0,  4'd5, 4'd0, 4'd7, 4'd0, 4'd2};
    logic         tz [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int           tl [7] = '{5, 5, 5, 5, 1, 5, 5};
    int lat, bc;
    logic [W-1:0] q, r;
    logic z;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], lat, bc, q, r, z);
      n_cmp += 5;
      if (lat != tl[i]) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, tl[i]); end
      if (bc != tl[i]) begin n_bad++; $display("FAIL dir%0d_busy_cycles: got %0d want %0d", i, bc, tl[i]); end
      if (q !== tq[i]) begin n_bad++; $display("FAIL dir%0d_quotient: got %0d want %0d", i, q, tq[i]); end
      if (r !== tr[i]) begin n_bad++; $display("FAIL dir%0d_remainder: got %0d want %0d", i, r, tr[i]); end
      if (z !== tz[i]) begin n_bad++; $display("FAIL dir%0d_dbz: got %b want %b", i, z, tz[i]); end
      // done is a single-cycle pulse and results hold afterwards
      @(posedge clk); #1;
      n_cmp += 3;
      if (done !== 1'b0) begin n_bad++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
      if (busy !== 1'b0) begin n_bad++; $display("FAIL dir%0d_idle_busy: got %b want 0", i, busy); end
      if (quotient !== tq[i]) begin
        n_bad++; $display("FAIL dir%0d_hold: got %0d want %0d", i, quotient, tq[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] pend [$];
    logic [2*W-1:0] op;
    logic exp_done;
    @(negedge clk);
    dividend = W'($urandom); divisor = W'($urandom_range(1, 15)); start = 1'b1;
    for (int c = 0; c < 24; c++) begin
      if (c % 6 == 0) pend.push_back({dividend, divisor});
      @(posedge clk); #1;
      exp_done = (c % 6 == 5);
      n_cmp++;
      if (done !== exp_done) begin
        n_bad++; $display("FAIL b2b_done_c%0d: got %b want %b", c, done, exp_done);
      end
      if (done === 1'b1 && pend.size() > 0) begin
        op = pend.pop_front();
        n_cmp += 3;
        if (quotient !== op[2*W-1:W] / op[W-1:0]) begin
          n_bad++; $display("FAIL b2b_quotient_c%0d: got %0d want %0d", c, quotient,
                            op[2*W-1:W] / op[W-1:0]);
        end
        if (remainder !== op[2*W-1:W] % op[W-1:0]) begin
          n_bad++; $display("FAIL b2b_remainder_c%0d: got %0d want %0d", c, remainder,
                            op[2*W-1:W] % op[W-1:0]);
        end
        if (div_by_zero !== 1'b0) begin
          n_bad++; $display("FAIL b2b_dbz_c%0d: got %b want 0", c, div_by_zero);
        end
      end
      @(negedge clk);
      dividend = W'($urandom); divisor = W'($urandom_range(1, 15));
      if (c == 23) start = 1'b0;
    end
  endtask

  task automatic test_reset_mid_calc();
    int dones = 0;
    int lat, bc;
    logic [W-1:0] q, r;
    logic z;
    @(negedge clk);
    dividend = 4'd14; divisor = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp += 4;
    if (busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL rstmid_done: got %b want 0", done); end
    if (quotient !== '0) begin n_bad++; $display("FAIL rstmid_quotient: got %0d want 0", quotient); end
    if (remainder !== '0) begin n_bad++; $display("FAIL rstmid_remainder: got %0d want 0", remainder); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_cmp++;
    if (dones != 0) begin n_bad++; $display("FAIL rstmid_no_done: got %0d pulses want 0", dones); end
    run_op(4'd14, 4'd4, lat, bc, q, r, z);
    n_cmp += 3;
    if (lat != 5) begin n_bad++; $display("FAIL rstmid_retry_latency: got %0d want 5", lat); end
    if (q !== 4'd3) begin n_bad++; $display("FAIL rstmid_retry_quotient: got %0d want 3", q); end
    if (r !== 4'd2) begin n_bad++; $display("FAIL rstmid_retry_remainder: got %0d want 2", r); end
  endtask

  // Exhaustive pairs followed by random operands, all against the reference.
  task automatic test_sweep();
    int lat, bc, elat;
    logic [W-1:0] q, r, eq, er, a, b;
    logic z, ez;
    for (int i = 0; i < 256 + 64; i++) begin
      if (i < 256) begin
        a = W'(i >> W); b = W'(i);
      end else begin
        a = W'($urandom); b = W'($urandom);
      end
      ref_div(a, b, eq, er, ez, elat);
      run_op(a, b, lat, bc, q, r, z);
      n_cmp += 4;
      if (lat != elat) begin n_bad++; $display("FAIL sweep_%0d/%0d_latency: got %0d want %0d", a, b, lat, elat); end
      if (q !== eq) begin n_bad++; $display("FAIL sweep_%0d/%0d_quotient: got %0d want %0d", a, b, q, eq); end
      if (r !== er) begin n_bad++; $display("FAIL sweep_%0d/%0d_remainder: got %0d want %0d", a, b, r, er); end
      if (z !== ez) begin n_bad++; $display("FAIL sweep_%0d/%0d_dbz: got %b want %b", a, b, z, ez); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_calc();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_restoring_divider.md
# seq_restoring_divider

Sequential unsigned restoring divider: the inverse-arithmetic companion to the team's registered 4-bit carry-lookahead adder. It accepts a dividend/divisor pair on a start pulse and produces one quotient bit per cycle using a CLA-based trial subtraction. It then presents quotient, remainder and a divide-by-zero flag with a one-cycle done pulse. It sits beside the adder in the arithmetic datapath and is driven by a simple start/busy/done handshake.

## Interface
- WIDTH, 4, operand/result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend, captured when start accepted
- divisor  input  WIDTH  unsigned divisor, captured when start accepted
- busy  output  1  high from the cycle after acceptance until done is asserted
- done  output  1  one-cycle pulse; results valid in that cycle
- quotient  output  WIDTH  unsigned quotient
- remainder  output  WIDTH  unsigned remainder
- div_by_zero  output  1  set with done when the captured divisor was 0

## Operation
- States: IDLE, CALC, DONE.
- IDLE with start=1:
  - Capture the operands.
  - Clear the partial remainder R (WIDTH+1 bits).
  - Load the quotient shift register Q with the dividend.
  - Set cnt = WIDTH-1.
  - Next state is CALC, or DONE directly if divisor==0.
- CALC step, one per cycle:
  - Form S = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - Compute T = S − {0,D} as S + ~{0,D} + 1 through the CLA subtractor.
  - If carry-out=1 (no borrow): R←T, Q←{Q[WIDTH-2:0],1}.
  - Otherwise: R←S, Q←{Q[WIDTH-2:0],0}.
  - cnt decrements each step. After the step with cnt==0, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy drops in the same cycle.
  - quotient=Q, remainder=R[WIDTH-1:0].
  - Next state is IDLE.
- Divide-by-zero: quotient = all ones, remainder = captured dividend, div_by_zero=1.
- Results and div_by_zero hold their values until the next accepted start. On acceptance, div_by_zero clears.
- start while busy or in DONE is ignored and not queued.
- Operands are not required to be stable after the acceptance cycle.

## Timing
- Reset state: IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, internal R/Q/cnt cleared.
- Start accepted on edge N:
  - busy=1 from edge N.
  - CALC occupies edges N+1..N+WIDTH.
  - done=1 after edge N+WIDTH+1, i.e. in the cycle following it.
- Normal latency: done appears WIDTH+1 cycles after acceptance (5 for WIDTH=4).
- Divide-by-zero latency: done appears 1 cycle after acceptance; CALC is skipped.
- Back-to-back: start may be high in the cycle done is high, but is accepted only once IDLE is reached. Minimum issue interval is WIDTH+2 cycles.
- rst during CALC or DONE: return to IDLE on the next edge, with all outputs at reset values, no done pulse, and the operation discarded.
- rst and start high together: rst wins.
- No combinational path from inputs to outputs; all outputs are registered.

## Structure
- Shared package `arith_pkg`:
  - state enum {IDLE, CALC, DONE}
  - DEFAULT_WIDTH = 4
  - count width = $clog2(WIDTH)
- Sub-module `cla_subtractor`: combinational, WIDTH+1 bits.
  - Computes A + ~B + 1 using per-bit generate/propagate and lookahead carries.
  - Outputs diff and cout, where cout=1 means A≥B.
  - Reusable by other datapath blocks.
- Top level holds the FSM, counter, R/Q registers and output registers.

## Test plan
- Reset, then dividend=13, divisor=3, start for 1 cycle:
  - busy high for 5 cycles.
  - done pulses 5 cycles after acceptance with quotient=4, remainder=1, div_by_zero=0.
- 15/1 → quotient=15, remainder=0; 5/9 → quotient=0, remainder=5; 0/7 → quotient=0, remainder=0.
- 7/0:
  - done 1 cycle after acceptance with quotient=15, remainder=7, div_by_zero=1.
  - The following 6/2 gives quotient=3, remainder=0 with div_by_zero=0.
- start held high continuously with changing operands:
  - Only operands at the acceptance edges are used.
  - Issue interval is exactly 6 cycles.
  - Each result matches the operands captured at its acceptance edge.
- Assert rst at CALC cycle 2 of 14/4:
  - No done pulse, busy=0, outputs zero.
  - A fresh 14/4 then yields quotient=3, remainder=2.
- Exhaustive sweep over all 256 pairs (WIDTH=4) against a reference model: quotient = a/b and remainder = a%b for b≠0; divide-by-zero rule for b=0.
